// File: rtl/cu_pipe_ctrl.sv
// Pipelined MIPS main control: decodes the opcode in ID and carries the EX, M and WB
// control bundles through ID/EX, EX/MEM and MEM/WB with bubble, squash and illegal-opcode tracking.
module cu_pipe_ctrl #(
  parameter int OPW  = 6,
  parameter int AOPW = 3,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  UIn,
  input  logic            VIn,
  input  logic            Stall,
  input  logic            Flush,
  output logic            RegDs,
  output logic            ALUsrc,
  output logic [AOPW-1:0] AOp,
  output logic            Branch,
  output logic            MRead,
  output logic            MWrite,
  output logic            MtoR,
  output logic            Urw,
  output logic            Illegal,
  output logic [CNTW-1:0] IllCnt
);

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);

  localparam logic [AOPW-1:0] AOP_ADD  = AOPW'(3'b000);
  localparam logic [AOPW-1:0] AOP_SUB  = AOPW'(3'b001);
  localparam logic [AOPW-1:0] AOP_FUNC = AOPW'(3'b010);

  typedef struct packed {
    logic            reg_ds;
    logic            alu_src;
    logic [AOPW-1:0] aop;
  } ex_ctrl_t;

  typedef struct packed {
    logic branch;
    logic mread;
    logic mwrite;
  } m_ctrl_t;

  typedef struct packed {
    logic mtor;
    logic urw;
  } wb_ctrl_t;

  typedef struct packed {
    ex_ctrl_t ex;
    m_ctrl_t  m;
    wb_ctrl_t wb;
    logic     illegal;
  } id_ex_t;

  typedef struct packed {
    m_ctrl_t  m;
    wb_ctrl_t wb;
  } ex_mem_t;

  id_ex_t          dec;
  logic            accept;
  id_ex_t          id_ex_d,   id_ex_q;
  ex_mem_t         ex_mem_d,  ex_mem_q;
  wb_ctrl_t        mem_wb_d,  mem_wb_q;
  logic [CNTW-1:0] ill_cnt_d, ill_cnt_q;

  // Opcode decode; anything unrecognised (including X in simulation) decodes to an illegal bubble.
  always_comb begin
    // NOTE: defaults first so every path assigns every bit; no latch is inferred.
    dec = '0;
    case (UIn)
      OP_RTYPE: begin
        dec.ex = '{reg_ds: 1'b1, alu_src: 1'b0, aop: AOP_FUNC};
        dec.wb = '{mtor: 1'b1, urw: 1'b1};
      end
      OP_LW: begin
        dec.ex = '{reg_ds: 1'b0, alu_src: 1'b1, aop: AOP_ADD};
        dec.m  = '{branch: 1'b0, mread: 1'b1, mwrite: 1'b0};
        dec.wb = '{mtor: 1'b0, urw: 1'b1};
      end
      OP_SW: begin
        dec.ex = '{reg_ds: 1'b0, alu_src: 1'b1, aop: AOP_ADD};
        dec.m  = '{branch: 1'b0, mread: 1'b0, mwrite: 1'b1};
      end
      OP_BEQ: begin
        dec.ex = '{reg_ds: 1'b0, alu_src: 1'b0, aop: AOP_SUB};
        dec.m  = '{branch: 1'b1, mread: 1'b0, mwrite: 1'b0};
      end
      OP_ADDI: begin
        dec.ex = '{reg_ds: 1'b0, alu_src: 1'b1, aop: AOP_ADD};
        dec.wb = '{mtor: 1'b1, urw: 1'b1};
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Flush outranks Stall, but both produce the same ID/EX bubble.
  assign accept = VIn & ~Stall & ~Flush;

  always_comb begin
    id_ex_d  = accept ? dec : '0;
    ex_mem_d = Flush ? '0 : '{m: id_ex_q.m, wb: id_ex_q.wb};
    mem_wb_d = ex_mem_q.wb;
    ill_cnt_d = ill_cnt_q;
    if (accept && dec.illegal && (ill_cnt_q != {CNTW{1'b1}})) begin
      ill_cnt_d = ill_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every stage updates from pre-edge values.
    if (rst) begin
      id_ex_q   <= '0;
      ex_mem_q  <= '0;
      mem_wb_q  <= '0;
      ill_cnt_q <= '0;
    end else begin
      id_ex_q   <= id_ex_d;
      ex_mem_q  <= ex_mem_d;
      mem_wb_q  <= mem_wb_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  assign RegDs   = id_ex_q.ex.reg_ds;
  assign ALUsrc  = id_ex_q.ex.alu_src;
  assign AOp     = id_ex_q.ex.aop;
  assign Illegal = id_ex_q.illegal;
  assign Branch  = ex_mem_q.m.branch;
  assign MRead   = ex_mem_q.m.mread;
  assign MWrite  = ex_mem_q.m.mwrite;
  assign MtoR    = mem_wb_q.mtor;
  assign Urw     = mem_wb_q.urw;
  assign IllCnt  = ill_cnt_q;

endmodule

// File: doc/cu_pipe_ctrl.md
Name: cu_pipe_ctrl

Overview:
Pipelined main control unit for the MIPS datapath. It decodes the 6-bit opcode in ID and carries the EX, M and WB control bundles through the ID/EX, EX/MEM and MEM/WB registers. It inserts bubbles on stall, squashes on branch flush, flags illegal opcodes and counts them. Unknown opcodes produce a safe bubble, never X.

Parameters:
OPW, 6, opcode width (UIn); only the value 6 is supported for decode.
AOPW, 3, ALU-op field width; codes are zero-extended to AOPW.
CNTW, 8, width of the illegal-opcode counter; the counter saturates.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
UIn  in  OPW  opcode of the instruction in ID.
VIn  in  1  ID slot holds a valid instruction.
Stall  in  1  load-use hazard: inject a bubble into ID/EX.
Flush  in  1  branch taken in MEM: squash ID/EX and EX/MEM.
RegDs  out  1  EX: destination register select (1 = rd).
ALUsrc  out  1  EX: ALU B source (1 = immediate).
AOp  out  AOPW  EX: ALU operation class.
Branch  out  1  MEM: branch instruction.
MRead  out  1  MEM: data memory read.
MWrite  out  1  MEM: data memory write.
MtoR  out  1  WB: writeback select (1 = ALU result, 0 = memory data).
Urw  out  1  WB: register file write enable.
Illegal  out  1  EX: instruction now in EX had an unknown opcode.
IllCnt  out  CNTW  count of illegal opcodes accepted.

Behaviour:
- Decode (combinational, ID). Fields are {RegDs, ALUsrc, AOp, Branch, MRead, MWrite, MtoR, Urw}:
  - 000000 R-type: 1, 0, 010, 0, 0, 0, 1, 1
  - 100011 lw: 0, 1, 000, 0, 1, 0, 0, 1
  - 101011 sw: 0, 1, 000, 0, 0, 1, 0, 0
  - 000100 beq: 0, 0, 001, 1, 0, 0, 0, 0
  - 001000 addi: 0, 1, 000, 0, 0, 0, 1, 1
  - Any other opcode: all zero, and the illegal bit is set.
- Bubble: all control bits 0, Illegal 0. A bubble has no architectural side effect.
- ID/EX register:
  - Loads the decode when VIn=1, Stall=0 and Flush=0.
  - Loads a bubble otherwise. Upstream holds the PC/IF-ID while Stall=1.
- EX/MEM register:
  - Loads the M and WB parts of ID/EX.
  - Loads a bubble when Flush=1.
- MEM/WB register: loads the WB part of EX/MEM unconditionally. An instruction already in MEM is never squashed.
- Latency: EX outputs valid 1 cycle after UIn is sampled; MEM outputs after 2 cycles; WB outputs after 3 cycles.
- Priority: rst > Flush > Stall > VIn. Flush together with Stall gives a flush; the ID/EX bubble is the same either way.
- IllCnt:
  - Increments on a cycle where the decode is illegal, VIn=1, Stall=0 and Flush=0, i.e. when the instruction enters EX.
  - Saturates at 2^CNTW-1.
  - Cleared only by rst.
- Reset: every pipeline register, every output and IllCnt go to 0 on the first clk edge with rst=1. A reset mid-stream discards all in-flight control with no partial writes.
- Outputs are register outputs only; there is no combinational path from inputs to outputs.

Test Plan:
- Reset, then UIn=000000, VIn=1 for one cycle -> next cycle RegDs=1, AOp=010, ALUsrc=0; cycle +3 MtoR=1, Urw=1; all other outputs 0.
- Back-to-back lw, sw, beq, addi -> EX/MEM/WB outputs match the table at latencies 1/2/3, with no cross-contamination between stages.
- lw in ID with Stall=1 for 1 cycle -> ID/EX holds a bubble (all EX outputs 0) that cycle; MRead=1 appears one cycle later than without the stall.
- beq in MEM with Flush=1, and sw in EX, add in ID -> MWrite stays 0 and the add never sets Urw; beq's own Branch=1 remains visible that cycle.
- UIn=111111, VIn=1, repeated 260 times with CNTW=8 -> Illegal=1 in EX each time, all controls 0, IllCnt saturates at 255. Flush or Stall on an illegal opcode -> no increment.
- rst asserted while sw is in EX/MEM -> next cycle MWrite=0, IllCnt=0, all outputs 0.
